// File: rtl/rr_arbiter_4_pkg.sv
// rtl/rr_arbiter_4_pkg.sv - shared mux-arbiter defines: state encodings, hold default, next-owner search
package rr_arbiter_4_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int MAX_HOLD_DEFAULT = 4;

  // Returns {found, index} of the first set bit in req, searching from last+1 and wrapping.
  function automatic logic [2:0] pick_next(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] result;
    logic [1:0] cand;
    result = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!result[2] && req[cand]) begin
        result = {1'b1, cand};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// rtl/mux_4_1.sv - gate-level 4:1 multiplexer, Y = I[{S1,S0}]
module mux_4_1 (
  input  logic I0,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic S0,
  input  logic S1,
  output logic Y
);

  wire ns0, ns1, a0, a1, a2, a3;

  not u_ns0 (ns0, S0);
  not u_ns1 (ns1, S1);
  and u_a0 (a0, I0, ns1, ns0);
  and u_a1 (a1, I1, ns1, S0);
  and u_a2 (a2, I2, S1, ns0);
  and u_a3 (a3, I3, S1, S0);
  or  u_y  (Y, a0, a1, a2, a3);

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter with hold limit driving a shared 4:1 mux
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  arb_state_t state, state_n;
  logic [3:0] gnt_n;
  logic [1:0] sel_n, last, last_n;
  logic       valid_n;
  logic [3:0] hold, hold_n;
  logic [3:0] others;
  logic [2:0] pick_any, pick_other;
  logic       do_grant;
  logic [1:0] grant_idx;
  logic       mux_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'd0;
      valid <= 1'b0;
      last  <= 2'd3;
      hold  <= 4'd0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      valid <= valid_n;
      last  <= last_n;
      hold  <= hold_n;
    end
  end

  // The owner is masked out of the competing set, so a release or pre-empt never regrants it.
  assign others     = req & ~gnt;
  assign pick_any   = pick_next(req, last);
  assign pick_other = pick_next(others, last);

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    sel_n     = sel;
    valid_n   = valid;
    last_n    = last;
    hold_n    = hold;
    do_grant  = 1'b0;
    grant_idx = 2'd0;
    case (state)
      ST_IDLE: begin
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
        if (pick_any[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_any[1:0];
        end
      end
      ST_GRANT: begin
        if (req[sel] && (hold < HOLD_MAX || others == 4'b0000)) begin
          if (hold < HOLD_MAX) hold_n = hold + 4'd1;
        end else if (pick_other[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_other[1:0];
        end else begin
          state_n = ST_IDLE;
          gnt_n   = 4'b0000;
          valid_n = 1'b0;
          hold_n  = 4'd0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = 4'b0000;
        valid_n = 1'b0;
      end
    endcase
    if (do_grant) begin
      state_n = ST_GRANT;
      gnt_n   = 4'b0001 << grant_idx;
      sel_n   = grant_idx;
      valid_n = 1'b1;
      last_n  = grant_idx;
      hold_n  = 4'd1;
    end
  end

  mux_4_1 u_mux (
    .I0 (din[0]),
    .I1 (din[1]),
    .I2 (din[2]),
    .I3 (din[3]),
    .S0 (sel[0]),
    .S1 (sel[1]),
    .Y  (mux_y)
  );

  assign y = mux_y & valid;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - directed scoreboard bench for rr_arbiter_4
module tb_rr_arbiter_4;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       y;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .sel   (sel),
    .valid (valid),
    .y     (y)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic [3:0] g, logic [1:0] s, logic v, logic yy);
    exp_t e;
    e.gnt = g; e.sel = s; e.valid = v; e.y = yy;
    return e;
  endfunction

  task automatic check(string tag);
    exp_t e;
    exp_t obs;
    e   = exp_q.pop_front();
    obs = {gnt, sel, valid, y};
    n_checks++;
    assert (obs === e)
    else begin
      n_fail++;
      $error("FAIL %s: observed gnt=%b sel=%0d valid=%b y=%b, expected gnt=%b sel=%0d valid=%b y=%b",
             tag, obs.gnt, obs.sel, obs.valid, obs.y, e.gnt, e.sel, e.valid, e.y);
    end
  endtask

  task automatic step(string tag, logic [3:0] r, logic [3:0] d, exp_t e);
    req = r;
    din = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = 4'b0000;
    #2;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    check("reset_state");

    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_reset", 4'b0000, 4'b0000, mk(4'b0000, 2'd0, 1'b0, 1'b0));

    step("first_grant_req0", 4'b0001, 4'b0001, mk(4'b0001, 2'd0, 1'b1, 1'b1));
    step("owner0_second",    4'b0001, 4'b0001, mk(4'b0001, 2'd0, 1'b1, 1'b1));
    step("handover_to3",     4'b1000, 4'b0001, mk(4'b1000, 2'd3, 1'b1, 1'b0));
    step("owner3_y",         4'b1000, 4'b1000, mk(4'b1000, 2'd3, 1'b1, 1'b1));
    step("idle_sel_holds",   4'b0000, 4'b1000, mk(4'b0000, 2'd3, 1'b0, 1'b0));

    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 4; c++) begin
        step($sformatf("rr_all_o%0d_c%0d", o, c), 4'b1111, 4'b1111,
             mk(4'b0001 << (o % 4), 2'(o % 4), 1'b1, 1'b1));
      end
    end

    step("release_to1", 4'b0010, 4'b0000, mk(4'b0010, 2'd1, 1'b1, 1'b0));
    for (int c = 0; c < 10; c++) begin
      step($sformatf("solo1_c%0d", c), 4'b0010, 4'b0010, mk(4'b0010, 2'd1, 1'b1, 1'b1));
    end

    step("release_to2",  4'b0100, 4'b0100, mk(4'b0100, 2'd2, 1'b1, 1'b1));
    step("drop_to_idle", 4'b0000, 4'b0100, mk(4'b0000, 2'd2, 1'b0, 1'b0));
    step("regrant2",     4'b0100, 4'b0100, mk(4'b0100, 2'd2, 1'b1, 1'b1));
    for (int c = 0; c < 3; c++) begin
      step($sformatf("hold2_c%0d", c), 4'b0101, 4'b0000, mk(4'b0100, 2'd2, 1'b1, 1'b0));
    end
    step("preempt_to0",  4'b0101, 4'b0001, mk(4'b0001, 2'd0, 1'b1, 1'b1));
    step("fair_to1",     4'b0110, 4'b0010, mk(4'b0010, 2'd1, 1'b1, 1'b1));

    #3;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0, 1'b0));
    check("async_reset_drop");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset_1010", 4'b1010, 4'b1111, mk(4'b0010, 2'd1, 1'b1, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
